// File: rtl/alarm_time_set.sv
`default_nettype none
// ============================================================================
// Module      : alarm_time_set
// Description : Alarm hour/minute setter with up/down auto-repeat stepping and
//               a ring/snooze/timeout state machine. Optional macro
//               ALARM_12H_EN adds a 12-hour view of the alarm hour.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_time_set #(
    parameter int W            = 6,
    parameter int HOUR_MOD     = 24,
    parameter int MIN_MOD      = 60,
    parameter int REPEAT_DELAY = 6,
    parameter int REPEAT_RATE  = 2,
    parameter int RING_TICKS   = 180,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic         clock,
    input  logic         reset_hour,
    input  logic         enable,
    input  logic         sel_field,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         alarm_on,
    input  logic         snooze,
    input  logic         stop,
    input  logic [W-1:0] cur_hour,
    input  logic [W-1:0] cur_min,
    input  logic [W-1:0] cur_sec,
    output logic [W-1:0] alarm_hour,
    output logic [W-1:0] alarm_min,
    output logic         ringing,
    output logic         snoozing
`ifdef ALARM_12H_EN
    ,
    output logic [W-1:0] alarm_hour12,
    output logic         alarm_pm
`endif
);

    localparam int RPT_W  = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int RING_W = $clog2(RING_TICKS + 1);

    localparam logic [RPT_W-1:0]  RPT_FIRE  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_DELAY + REPEAT_RATE - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TICKS - 1);
    localparam logic [W-1:0]      HOUR_MAX  = W'(HOUR_MOD - 1);
    localparam logic [W-1:0]      MIN_MAX   = W'(MIN_MOD - 1);
    localparam logic [W:0]        SNZ_ADD   = (W+1)'(SNOOZE_MIN);
    localparam logic [W:0]        MIN_MOD_X = (W+1)'(MIN_MOD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t            state, next_state;
    logic              up_q, down_q, sel_q;
    logic [RPT_W-1:0]  rpt_cnt, rpt_next;
    logic [RING_W-1:0] ring_cnt;
    logic [W-1:0]      snz_hour, snz_min, snz_hour_next, snz_min_next;
    logic [W:0]        snz_sum;
    logic              snz_wrap, snz_load, snz_hit, match;
    logic              rpt_active, rpt_fire, up_step, down_step;
    logic [W-1:0]      hour_inc, hour_dec, min_inc, min_dec;

    // Repeat counter runs only while a single button is held on a stable field.
    always_comb begin
        rpt_active = enable && (btn_up ^ btn_down) && (sel_field == sel_q);
        rpt_fire   = rpt_active && (rpt_cnt == RPT_FIRE);
        up_step    = enable && btn_up && !btn_down && (!up_q || rpt_fire);
        down_step  = enable && btn_down && !btn_up && (!down_q || rpt_fire);
        if (!rpt_active)
            rpt_next = '0;
        else if (rpt_cnt == RPT_LAST)
            rpt_next = RPT_FIRE;
        else
            rpt_next = rpt_cnt + RPT_W'(1);
    end

    always_comb begin
        hour_inc = (alarm_hour == HOUR_MAX) ? '0 : alarm_hour + W'(1);
        hour_dec = (alarm_hour == '0) ? HOUR_MAX : alarm_hour - W'(1);
        min_inc  = (alarm_min == MIN_MAX) ? '0 : alarm_min + W'(1);
        min_dec  = (alarm_min == '0) ? MIN_MAX : alarm_min - W'(1);
    end

    // Snooze target: current time plus SNOOZE_MIN, carrying into the hour.
    always_comb begin
        snz_sum       = {1'b0, cur_min} + SNZ_ADD;
        snz_wrap      = (snz_sum >= MIN_MOD_X);
        snz_min_next  = W'(snz_wrap ? snz_sum - MIN_MOD_X : snz_sum);
        snz_hour_next = !snz_wrap ? cur_hour :
                        (cur_hour == HOUR_MAX) ? '0 : cur_hour + W'(1);
        match   = alarm_on && !enable && (cur_hour == alarm_hour) &&
                  (cur_min == alarm_min) && (cur_sec == '0);
        snz_hit = (cur_hour == snz_hour) && (cur_min == snz_min) && (cur_sec == '0);
    end

    always_comb begin
        next_state = state;
        snz_load   = 1'b0;
        case (state)
            IDLE:
                if (match)
                    next_state = RING;
            RING:
                if (stop)
                    next_state = IDLE;
                else if (snooze) begin
                    next_state = SNOOZE;
                    snz_load   = 1'b1;
                end else if (ring_cnt == RING_LAST)
                    next_state = IDLE;
            SNOOZE:
                if (stop)
                    next_state = IDLE;
                else if (snz_hit)
                    next_state = RING;
            default:
                next_state = IDLE;
        endcase
        if (!alarm_on || enable)
            next_state = IDLE;
    end

    always_ff @(posedge clock or posedge reset_hour) begin
        if (reset_hour) begin
            state      <= IDLE;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            sel_q      <= 1'b0;
            rpt_cnt    <= '0;
            ring_cnt   <= '0;
            snz_hour   <= '0;
            snz_min    <= '0;
            alarm_hour <= '0;
            alarm_min  <= '0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state    <= next_state;
            up_q     <= btn_up;
            down_q   <= btn_down;
            sel_q    <= sel_field;
            rpt_cnt  <= rpt_next;
            ring_cnt <= (state == RING && next_state == RING) ? ring_cnt + RING_W'(1) : '0;
            ringing  <= (next_state == RING);
            snoozing <= (next_state == SNOOZE);
            if (snz_load) begin
                snz_hour <= snz_hour_next;
                snz_min  <= snz_min_next;
            end else if (next_state == IDLE) begin
                snz_hour <= '0;
                snz_min  <= '0;
            end
            if (up_step || down_step) begin
                if (!sel_field)
                    alarm_hour <= up_step ? hour_inc : hour_dec;
                else
                    alarm_min  <= up_step ? min_inc : min_dec;
            end
        end
    end

`ifdef ALARM_12H_EN
    generate
        if (HOUR_MOD != 24) begin : g_bad_hour_mod
            $error("ALARM_12H_EN requires HOUR_MOD == 24");
        end
    endgenerate

    always_comb begin
        alarm_pm = (alarm_hour >= W'(12));
        if (alarm_hour == '0)
            alarm_hour12 = W'(12);
        else if (alarm_hour > W'(12))
            alarm_hour12 = alarm_hour - W'(12);
        else
            alarm_hour12 = alarm_hour;
    end
`endif

endmodule
`default_nettype wire
